// File: rtl/kat_adc_cfg_pkg.sv
// Shared types and widths for the KAT ADC configuration sequencer.
package kat_adc_cfg_pkg;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;
   localparam int IDX_W  = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RST_PULSE,
      ST_RST_WAIT,
      ST_TBL_RD,
      ST_ISSUE,
      ST_BLANK,
      ST_WAIT_DONE,
      ST_PS_STEP,
      ST_PS_WAIT,
      ST_DONE,
      ST_ERROR,
      ST_SW_ISSUE
   } state_t;

   // Timer must hold the largest preload; never narrower than 10 bits.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      int w;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      w = $clog2(m + 1);
      return (w < 10) ? 10 : w;
   endfunction

   function automatic logic is_rest(input state_t s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
   endfunction
endpackage

// File: rtl/kat_adc_cfg_timer.sv
// Loadable down-counter with zero flag; load wins over counting, stops at zero.
module kat_adc_cfg_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);
endmodule

// File: rtl/kat_adc_cfg_sequencer.sv
// Power-up configuration sequencer for one KAT ADC: reset pulse, settle, table writes,
// MMCM phase steps, with software single writes sharing the SPI config port.
module kat_adc_cfg_sequencer
   import kat_adc_cfg_pkg::*;
#(
   parameter int NUM_WORDS = 8,
   parameter int RST_HOLD  = 16,
   parameter int RST_WAIT  = 256,
   parameter int PS_STEPS  = 0,
   parameter int PS_INC    = 1,
   parameter int TIMEOUT   = 1023,
   parameter int AUTOSTART = 1
) (
   input  logic              wbs_clk_i,
   input  logic              wbs_rst_n_i,
   input  logic              start_i,
   input  logic              sw_req_i,
   input  logic [ADDR_W-1:0] sw_addr_i,
   input  logic [DATA_W-1:0] sw_data_i,
   output logic              sw_gnt_o,
   output logic              sw_done_o,
   output logic [IDX_W-1:0]  tbl_idx_o,
   input  logic [ADDR_W-1:0] tbl_addr_i,
   input  logic [DATA_W-1:0] tbl_data_i,
   output logic [ADDR_W-1:0] cfg_addr_o,
   output logic [DATA_W-1:0] cfg_data_o,
   output logic              cfg_start_o,
   input  logic              cfg_done_i,
   output logic              adc_reset_o,
   output logic              psen_o,
   output logic              psincdec_o,
   input  logic              psdone_i,
   output logic              busy_o,
   output logic              cal_done_o,
   output logic              error_o
);
   localparam int TMR_W = timer_width(RST_HOLD, RST_WAIT, TIMEOUT);
   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(RST_HOLD - 1);
   localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(RST_WAIT - 1);
   localparam logic [TMR_W-1:0] TOUT_LOAD = TMR_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
   localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(PS_STEPS - 1);
   localparam state_t AFTER_WR = (PS_STEPS == 0) ? ST_DONE : ST_PS_STEP;

   state_t              state_reg;
   state_t              ret_state_reg;
   logic                auto_pend_reg;
   logic                sw_flag_reg;
   logic [IDX_W-1:0]    idx_reg;
   logic [IDX_W-1:0]    step_reg;
   logic [IDX_W-1:0]    tbl_idx_reg;
   logic [ADDR_W-1:0]   cfg_addr_reg;
   logic [DATA_W-1:0]   cfg_data_reg;
   logic                cfg_start_reg;
   logic                adc_reset_reg;
   logic                psen_reg;
   logic                psincdec_reg;
   logic                sw_gnt_reg;
   logic                sw_done_reg;
   logic                cal_done_reg;
   logic                error_reg;

   logic                tmr_load;
   logic [TMR_W-1:0]    tmr_load_val;
   logic                tmr_zero;

   // Preload is chosen by the state that precedes each timed state, so the
   // timer starts counting on the same edge the timed state is entered.
   always_comb begin
      tmr_load     = 1'b0;
      tmr_load_val = TOUT_LOAD;
      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            tmr_load     = 1'b1;
            tmr_load_val = (start_i || auto_pend_reg) ? HOLD_LOAD : TOUT_LOAD;
         end
         ST_RST_PULSE: begin
            tmr_load     = tmr_zero;
            tmr_load_val = WAIT_LOAD;
         end
         ST_TBL_RD, ST_BLANK, ST_PS_STEP: tmr_load = 1'b1;
         default: ;
      endcase
   end

   kat_adc_cfg_timer #(.W(TMR_W)) u_timer (
      .clk      (wbs_clk_i),
      .rst_n    (wbs_rst_n_i),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
      if (!wbs_rst_n_i) begin
         state_reg     <= ST_IDLE;
         ret_state_reg <= ST_IDLE;
         auto_pend_reg <= (AUTOSTART != 0);
         sw_flag_reg   <= 1'b0;
         idx_reg       <= '0;
         step_reg      <= '0;
         tbl_idx_reg   <= '0;
         cfg_addr_reg  <= '0;
         cfg_data_reg  <= '0;
         cfg_start_reg <= 1'b0;
         adc_reset_reg <= 1'b0;
         psen_reg      <= 1'b0;
         psincdec_reg  <= 1'b0;
         sw_gnt_reg    <= 1'b0;
         sw_done_reg   <= 1'b0;
         cal_done_reg  <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         cfg_start_reg <= 1'b0;
         psen_reg      <= 1'b0;
         sw_gnt_reg    <= 1'b0;
         sw_done_reg   <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (state_reg == ST_DONE) cal_done_reg <= 1'b1;
               if (start_i || auto_pend_reg) begin
                  state_reg     <= ST_RST_PULSE;
                  adc_reset_reg <= 1'b1;
                  cal_done_reg  <= 1'b0;
                  error_reg     <= 1'b0;
                  idx_reg       <= '0;
                  step_reg      <= '0;
                  tbl_idx_reg   <= '0;
                  auto_pend_reg <= 1'b0;
                  sw_flag_reg   <= 1'b0;
               end else if (sw_req_i) begin
                  cfg_addr_reg  <= sw_addr_i;
                  cfg_data_reg  <= sw_data_i;
                  sw_gnt_reg    <= 1'b1;
                  sw_flag_reg   <= 1'b1;
                  ret_state_reg <= state_reg;
                  state_reg     <= ST_SW_ISSUE;
               end
            end
            ST_RST_PULSE: begin
               if (tmr_zero) begin
                  adc_reset_reg <= 1'b0;
                  state_reg     <= ST_RST_WAIT;
               end
            end
            ST_RST_WAIT: begin
               if (tmr_zero) state_reg <= (NUM_WORDS == 0) ? AFTER_WR : ST_TBL_RD;
            end
            ST_TBL_RD: begin
               cfg_addr_reg <= tbl_addr_i;
               cfg_data_reg <= tbl_data_i;
               state_reg    <= ST_ISSUE;
            end
            ST_ISSUE, ST_SW_ISSUE: begin
               if (cfg_done_i) begin
                  cfg_start_reg <= 1'b1;
                  state_reg     <= ST_BLANK;
               end else if (tmr_zero) begin
                  state_reg   <= ST_ERROR;
                  error_reg   <= 1'b1;
                  sw_done_reg <= sw_flag_reg;
                  sw_flag_reg <= 1'b0;
               end
            end
            ST_BLANK: begin
               // Prefetch the next table index so registered table data is ready by TBL_RD.
               if (!sw_flag_reg) tbl_idx_reg <= idx_reg + 1'b1;
               state_reg <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (cfg_done_i) begin
                  if (sw_flag_reg) begin
                     sw_done_reg <= 1'b1;
                     sw_flag_reg <= 1'b0;
                     state_reg   <= ret_state_reg;
                  end else if (idx_reg == LAST_IDX) begin
                     state_reg <= AFTER_WR;
                  end else begin
                     idx_reg   <= idx_reg + 1'b1;
                     state_reg <= ST_TBL_RD;
                  end
               end else if (tmr_zero) begin
                  state_reg   <= ST_ERROR;
                  error_reg   <= 1'b1;
                  sw_done_reg <= sw_flag_reg;
                  sw_flag_reg <= 1'b0;
               end
            end
            ST_PS_STEP: begin
               psen_reg     <= 1'b1;
               psincdec_reg <= 1'(PS_INC);
               state_reg    <= ST_PS_WAIT;
            end
            ST_PS_WAIT: begin
               if (psdone_i) begin
                  if (step_reg == LAST_STEP) begin
                     state_reg <= ST_DONE;
                  end else begin
                     step_reg  <= step_reg + 1'b1;
                     state_reg <= ST_PS_STEP;
                  end
               end else if (tmr_zero) begin
                  state_reg <= ST_ERROR;
                  error_reg <= 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign busy_o      = !is_rest(state_reg);
   assign sw_gnt_o    = sw_gnt_reg;
   assign sw_done_o   = sw_done_reg;
   assign tbl_idx_o   = tbl_idx_reg;
   assign cfg_addr_o  = cfg_addr_reg;
   assign cfg_data_o  = cfg_data_reg;
   assign cfg_start_o = cfg_start_reg;
   assign adc_reset_o = adc_reset_reg;
   assign psen_o      = psen_reg;
   assign psincdec_o  = psincdec_reg;
   assign cal_done_o  = cal_done_reg;
   assign error_o     = error_reg;
endmodule

// File: tb/tb_kat_adc_cfg_sequencer.sv
// Directed bench: autostart run with phase steps, software writes, start/sw collision,
// SPI timeout and reset during a pending write, against a simple controller/table model.
module tb_kat_adc_cfg_sequencer;
   localparam int T_OUT = 64;

   logic        clk = 1'b0;
   logic        rst_n, start, sw_req;
   logic [3:0]  sw_addr;
   logic [15:0] sw_data;
   logic        sw_gnt, sw_done;
   logic [7:0]  tbl_idx;
   logic [3:0]  tbl_addr = '0;
   logic [15:0] tbl_data = '0;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        cfg_start, cfg_done = 1'b1;
   logic        adc_reset, psen, psincdec, psdone = 1'b0;
   logic        busy, cal_done, error;

   int          errors = 0, checks = 0;
   int          cyc = 0, start_cyc = 0;
   int          rst_hi_cnt = 0, psen_cnt = 0, psinc_cnt = 0, gnt_cnt = 0, done_cnt = 0;
   logic [19:0] words[$];
   logic        hang = 1'b0;

   always #5 clk = ~clk;

   kat_adc_cfg_sequencer #(
      .NUM_WORDS(3), .RST_HOLD(16), .RST_WAIT(20), .PS_STEPS(4),
      .PS_INC(1), .TIMEOUT(T_OUT), .AUTOSTART(1)
   ) dut (
      .wbs_clk_i(clk), .wbs_rst_n_i(rst_n), .start_i(start), .sw_req_i(sw_req),
      .sw_addr_i(sw_addr), .sw_data_i(sw_data), .sw_gnt_o(sw_gnt), .sw_done_o(sw_done),
      .tbl_idx_o(tbl_idx), .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data),
      .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data), .cfg_start_o(cfg_start),
      .cfg_done_i(cfg_done), .adc_reset_o(adc_reset), .psen_o(psen),
      .psincdec_o(psincdec), .psdone_i(psdone), .busy_o(busy),
      .cal_done_o(cal_done), .error_o(error)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial forever @(posedge clk) cyc++;

   // SPI controller, registered-read table and MMCM models, all updated mid-cycle.
   initial begin
      int cnt = 0, ps_cnt = 0, prev_idx = 0;
      forever @(negedge clk) begin
         tbl_addr = 4'(prev_idx + 1);
         tbl_data = 16'hC000 + 16'(prev_idx) * 16'h0111;
         prev_idx = int'(tbl_idx);
         if (adc_reset) rst_hi_cnt++;
         if (sw_gnt) begin gnt_cnt++; $display("sw grant addr=%h data=%h", sw_addr, sw_data); end
         if (sw_done) done_cnt++;
         if (!rst_n) begin
            cnt = 0; cfg_done = 1'b1; ps_cnt = 0; psdone = 1'b0;
         end else begin
            if (cfg_start) begin
               words.push_back({cfg_addr, cfg_data});
               start_cyc = cyc;
               $display("cfg write addr=%h data=%h", cfg_addr, cfg_data);
               cnt = 3; cfg_done = 1'b0;
            end else if (cnt > 0) begin
               cnt--;
               if (cnt == 0 && !hang) cfg_done = 1'b1;
            end else if (!hang) begin
               cfg_done = 1'b1;
            end
            psdone = 1'b0;
            if (psen) begin
               psen_cnt++;
               if (psincdec) psinc_cnt++;
               $display("phase step %0d inc=%0b", psen_cnt, psincdec);
               ps_cnt = 5;
            end else if (ps_cnt > 0) begin
               ps_cnt--;
               if (ps_cnt == 0) psdone = 1'b1;
            end
         end
      end
   end

   function automatic logic sel_sig(input int which);
      case (which)
         0: return cal_done;
         1: return sw_gnt;
         2: return sw_done;
         3: return error;
         default: return cfg_start;
      endcase
   endfunction

   task automatic wait_until(input int which, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (sel_sig(which)) break;
         @(negedge clk);
      end
   endtask

   task automatic clear_counts();
      rst_hi_cnt = 0; psen_cnt = 0; psinc_cnt = 0; gnt_cnt = 0; done_cnt = 0;
      words.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; sw_req = 1'b0; sw_addr = '0; sw_data = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_outputs", {busy, cal_done, error, adc_reset, cfg_start, psen, psincdec, sw_gnt, sw_done}, 0);
      check_val("reset_cfg_bus", {tbl_idx, cfg_addr, cfg_data}, 0);
      clear_counts();
      rst_n = 1'b1;
      @(negedge clk);
      check_val("autostart_reset_high", adc_reset, 1);

      // Autostart run: 3 table words then 4 phase steps.
      wait_until(0, 2000);
      check_val("run1_cal_done", cal_done, 1);
      check_val("run1_busy", busy, 0);
      check_val("run1_error", error, 0);
      check_val("run1_reset_cycles", rst_hi_cnt, 16);
      check_val("run1_word_count", words.size(), 3);
      if (words.size() == 3) begin
         check_val("run1_word0", words[0], {4'h1, 16'hC000});
         check_val("run1_word1", words[1], {4'h2, 16'hC111});
         check_val("run1_word2", words[2], {4'h3, 16'hC222});
      end
      check_val("run1_psen_count", psen_cnt, 4);
      check_val("run1_psincdec", psinc_cnt, 4);

      // Software write from DONE.
      repeat (2) @(negedge clk);
      clear_counts();
      sw_req = 1'b1; sw_addr = 4'h9; sw_data = 16'hA5C3;
      wait_until(1, 200);
      check_val("sw_grant_seen", sw_gnt, 1);
      sw_req = 1'b0;
      wait_until(2, 200);
      check_val("sw_done_seen", sw_done, 1);
      check_val("sw_word", (words.size() == 1) ? words[0] : 20'hFFFFF, {4'h9, 16'hA5C3});
      check_val("sw_grant_count", gnt_cnt, 1);
      check_val("sw_keeps_cal_done", {busy, cal_done}, 2'b01);

      // Start and software request together: start wins, grant only after DONE.
      repeat (2) @(negedge clk);
      clear_counts();
      sw_req = 1'b1; sw_addr = 4'h4; sw_data = 16'h1234;
      pulse_start();
      check_val("collide_busy", busy, 1);
      check_val("collide_no_grant", gnt_cnt, 0);
      wait_until(1, 3000);
      check_val("collide_grant_after_done", {sw_gnt, cal_done}, 2'b11);
      sw_req = 1'b0;
      wait_until(2, 200);
      check_val("collide_word_count", words.size(), 4);
      if (words.size() == 4) begin
         check_val("collide_first_word", words[0], {4'h1, 16'hC000});
         check_val("collide_last_word", words[3], {4'h4, 16'h1234});
      end

      // Controller never returns done: timeout to ERROR.
      repeat (2) @(negedge clk);
      clear_counts();
      hang = 1'b1;
      pulse_start();
      wait_until(4, 500);
      check_val("tout_start_seen", cfg_start, 1);
      @(negedge clk);
      wait_until(3, 500);
      check_val("tout_error", error, 1);
      check_val("tout_latency", cyc - start_cyc, T_OUT + 1);
      check_val("tout_cal_done", cal_done, 0);
      check_val("tout_busy", busy, 0);
      check_val("tout_word_count", words.size(), 1);
      hang = 1'b0;

      // Reset while a table write is pending in WAIT_DONE.
      repeat (2) @(negedge clk);
      pulse_start();
      check_val("rerun_clears_error", error, 0);
      wait_until(4, 500);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("midrun_reset_outputs", {busy, cal_done, error, adc_reset, cfg_start, psen, psincdec, sw_gnt, sw_done}, 0);
      check_val("midrun_reset_cfg_bus", {tbl_idx, cfg_addr, cfg_data}, 0);
      @(negedge clk);
      clear_counts();
      rst_n = 1'b1;
      wait_until(0, 2000);
      check_val("restart_cal_done", cal_done, 1);
      check_val("restart_reset_cycles", rst_hi_cnt, 16);
      check_val("restart_word_count", words.size(), 3);
      check_val("restart_word0", (words.size() > 0) ? words[0] : 20'hFFFFF, {4'h1, 16'hC000});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
